// File: rtl/seq_divide.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per clock,
// valid/ready handshakes on both the operand and the result side.
module seq_divide #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;       // partial remainder
    logic [WIDTH-1:0] quo;       // remaining dividend bits, quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] quo_step;
    logic             accept;
    logic             last_step;
    logic             dvs_zero;

    // One restoring step: shift in the next dividend bit, trial-subtract with a
    // spare MSB so the borrow is visible, keep the difference only if non-negative.
    function automatic logic [2*WIDTH-1:0] restore_step(
        input logic [WIDTH-1:0] acc_in,
        input logic [WIDTH-1:0] quo_in,
        input logic [WIDTH-1:0] dvs_in
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        logic [WIDTH:0] quo_ext;
        logic           q_bit;
        shifted = {acc_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_in};
        q_bit   = ~diff[WIDTH];
        quo_ext = {quo_in, q_bit};
        if (q_bit)
            return {diff[WIDTH-1:0], quo_ext[WIDTH-1:0]};
        else
            return {shifted[WIDTH-1:0], quo_ext[WIDTH-1:0]};
    endfunction

    always_comb begin
        {acc_step, quo_step} = restore_step(acc, quo, dvs);
    end

    assign dvs_zero  = (dvs == '0);
    assign last_step = (state == BUSY) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A zero divisor spends a single BUSY cycle, so its latency is one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt <= (divisor == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (last_step) begin
                if (dvs_zero) begin
                    quotient    <= '1;
                    remainder   <= quo;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= quo_step;
                    remainder   <= acc_step;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            acc <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (state == BUSY) begin
            acc <= acc_step;
            quo <= quo_step;
        end
    end

endmodule
